// File: rtl/serial_in_pkg.sv
// Shared definitions for the serial input conditioning stage and the
// bit-sequence detectors: state encoding and default qualification length.
package serial_in_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'b00,
      CHK_HI = 2'b01,
      HIGH   = 2'b10,
      CHK_LO = 2'b11
   } state_t;

   localparam int DEF_STABLE_CNT = 4;
   localparam int DEF_CNT_W      = 4;

   function automatic logic is_chk(input state_t st);
      return (st == CHK_HI) || (st == CHK_LO);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared to 0 by the
// active-low asynchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/serial_in_debounce.sv
// Synchronizes and debounces a raw serial input into a clean level x_out.
// Optional edge strobes x_rise/x_fall are built when DEBOUNCE_EDGE_EN is defined.
module serial_in_debounce
   import serial_in_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic x_raw,
   output logic x_out,
   output logic busy,
   output logic x_rise,
   output logic x_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             s;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             x_nxt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (x_raw),
      .q   (s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= LOW;
         cnt   <= '0;
         x_out <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         x_out <= x_nxt;
         busy  <= is_chk(state_nxt);
      end
   end

   // cnt defaults to 0 so it is held clear in stable states and restarts on a bounce.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      x_nxt     = x_out;
      case (state)
         LOW: begin
            x_nxt = 1'b0;
            if (s) state_nxt = CHK_HI;
         end
         CHK_HI: begin
            if (!s) begin
               state_nxt = LOW;
            end else if (cnt == CNT_LAST) begin
               state_nxt = HIGH;
               x_nxt     = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HIGH: begin
            x_nxt = 1'b1;
            if (!s) state_nxt = CHK_LO;
         end
         CHK_LO: begin
            if (s) begin
               state_nxt = HIGH;
            end else if (cnt == CNT_LAST) begin
               state_nxt = LOW;
               x_nxt     = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = LOW;
            x_nxt     = 1'b0;
         end
      endcase
   end

`ifdef DEBOUNCE_EDGE_EN
   // Strobes register alongside x_out, so they coincide with its change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_rise <= 1'b0;
         x_fall <= 1'b0;
      end else begin
         x_rise <= x_nxt & ~x_out;
         x_fall <= ~x_nxt & x_out;
      end
   end
`else
   assign x_rise = 1'b0;
   assign x_fall = 1'b0;
`endif

endmodule

// File: tb/tb_serial_in_debounce.sv
// Self-checking bench for serial_in_debounce: directed scenarios plus random
// bursts, compared against a run-length model of the debounce rule.
module tb_serial_in_debounce;

   localparam int STABLE_CNT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic x_raw = 1'b0;
   logic x_out, busy, x_rise, x_fall;

   int n_vec = 0;
   int n_err = 0;

   serial_in_debounce #(.STABLE_CNT(STABLE_CNT), .CNT_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .x_raw  (x_raw),
      .x_out  (x_out),
      .busy   (busy),
      .x_rise (x_rise),
      .x_fall (x_fall)
   );

   always #5 clk = ~clk;

   // Model: x_raw samples reach the debouncer two edges later; x_out flips once
   // the delayed input has disagreed with it on STABLE_CNT+1 consecutive edges.
   logic hist_q[$];
   logic exp_out, exp_busy, exp_rise, exp_fall;
   int   run;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist_q.delete();
      hist_q.push_back(1'b0);
      hist_q.push_back(1'b0);
      exp_out  = 1'b0;
      exp_busy = 1'b0;
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      run      = 0;
   endtask

   task automatic model_edge(input logic raw);
      logic seen;
      seen = hist_q.pop_front();
      hist_q.push_back(raw);
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      if (seen == exp_out) begin
         run = 0;
      end else begin
         run++;
         if (run == STABLE_CNT + 1) begin
            exp_rise = seen;
            exp_fall = ~seen;
            exp_out  = seen;
            run      = 0;
         end
      end
      exp_busy = (run != 0);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".x_out"}, 32'(x_out), 32'(exp_out));
      check({tag, ".busy"},  32'(busy),  32'(exp_busy));
`ifdef DEBOUNCE_EDGE_EN
      check({tag, ".x_rise"}, 32'(x_rise), 32'(exp_rise));
      check({tag, ".x_fall"}, 32'(x_fall), 32'(exp_fall));
`else
      check({tag, ".x_rise"}, 32'(x_rise), 32'd0);
      check({tag, ".x_fall"}, 32'(x_fall), 32'd0);
`endif
   endtask

   task automatic step(input logic v, input string tag);
      x_raw = v;
      @(posedge clk);
      model_edge(v);
      #1;
      check_outputs(tag);
   endtask

   // Holds level v and returns the number of edges after the first one
   // (E0) at which x_out is first seen equal to v; 99 if it never does.
   task automatic measure(input logic v, input string tag, output int lat);
      lat = 99;
      for (int i = 0; i < 20; i++) begin
         step(v, tag);
         if (x_out == v && lat == 99) lat = i;
      end
   endtask

   initial begin
      int lat;
      model_reset();

      // Reset held with x_raw high
      x_raw = 1'b1;
      #1;
      check_outputs("reset_hold");
      repeat (5) begin
         @(posedge clk);
         #1;
         check_outputs("reset_hold");
      end
      rst = 1'b1;
      measure(1'b1, "reset_rise", lat);
      check("reset_rise_latency", 32'(lat), 32'(STABLE_CNT + 2));

      // Clean fall from HIGH
      measure(1'b0, "clean_fall", lat);
      check("fall_latency", 32'(lat), 32'(STABLE_CNT + 2));

      // Clean rise from LOW
      measure(1'b1, "clean_rise", lat);
      check("rise_latency", 32'(lat), 32'(STABLE_CNT + 2));
      repeat (10) step(1'b0, "settle_low");

      // Bounce rejected: three-cycle pulse
      repeat (3) step(1'b1, "bounce");
      repeat (8) step(1'b0, "bounce");
      check("bounce_x_out", 32'(x_out), 32'd0);

      // Bounce then settle high
      step(1'b1, "toggle");
      step(1'b0, "toggle");
      step(1'b1, "toggle");
      step(1'b0, "toggle");
      measure(1'b1, "settle", lat);
      check("settle_latency", 32'(lat), 32'(STABLE_CNT + 2));
      repeat (10) step(1'b0, "settle_low2");

      // Reset while in CHK_HI with cnt=2
      repeat (5) step(1'b1, "mid_qual");
      check("mid_qual_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs("mid_reset");
      x_raw = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         check_outputs("mid_reset_hold");
      end
      rst = 1'b1;
      repeat (10) step(1'b0, "post_reset");

      // Random bursts of varying length, with an occasional reset
      for (int b = 0; b < 120; b++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         for (int k = 0; k < len; k++) step(lvl, "random");
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_outputs("random_reset");
            @(posedge clk);
            #1;
            rst = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
